bch_mchannel_err_stats: RTL and testbench

- Multi-channel, parametrised successor to the benchmark decoder wrapper's output stage.
- Sits after bch_decoder's err_out/first_out ports.
- Per channel, it frames the error stream into codewords, counts corrected bits per frame and keeps saturating running statistics.
- It flags framing faults and frames with more than T errors.
- Input pipeline depth is configurable for timing closure in the benchmark top.

---
 rtl/bch_mchannel_err_stats_pkg.sv | 46 ++++
 rtl/bch_err_chan_stats.sv | 117 +++++++++++
 rtl/bch_mchannel_err_stats.sv | 86 ++++++++
 tb/tb_bch_mchannel_err_stats.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_mchannel_err_stats_pkg.sv
// Shared constants and helpers for the multi-channel BCH error statistics block:
// frame geometry, popcount and saturating accumulation.
package bch_mchannel_err_stats_pkg;

  typedef enum logic {
    CH_IDLE   = 1'b0,
    CH_ACTIVE = 1'b1
  } chan_state_t;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int beats_f(input int data_bits, input int bits);
    return (data_bits + bits - 1) / bits;
  endfunction

  function automatic int last_bits_f(input int data_bits, input int bits);
    return data_bits - (beats_f(data_bits, bits) - 1) * bits;
  endfunction

  function automatic int errw_f(input int data_bits);
    return clog2_f(data_bits + 1);
  endfunction

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

  // Result clamps at 2^w-1; w is at most 32.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] sum;
    logic [32:0] lim;
    lim = (33'd1 << w) - 33'd1;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/bch_err_chan_stats.sv
// One channel: frames the error stream into codewords, counts errors per frame
// and keeps saturating totals plus sticky framing / excess flags.
//
//   state     | meaning
//   CH_IDLE   | waiting for a first beat; err bits ignored
//   CH_ACTIVE | mid-frame, accumulating beats 1..BEATS-1
module bch_err_chan_stats
  import bch_mchannel_err_stats_pkg::*;
#(
  parameter int T         = 3,
  parameter int DATA_BITS = 64,
  parameter int BITS      = 4,
  parameter int CNT_W     = 16,
  localparam int BEATS     = beats_f(DATA_BITS, BITS),
  localparam int LAST_BITS = last_bits_f(DATA_BITS, BITS),
  localparam int ERRW      = errw_f(DATA_BITS),
  localparam int BW        = (clog2_f(BEATS) < 1) ? 1 : clog2_f(BEATS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BITS-1:0]  err,
  input  logic             first,
  input  logic             clear,
  output logic             frame_done,
  output logic [ERRW-1:0]  frame_errs,
  output logic [CNT_W-1:0] total_errs,
  output logic [CNT_W-1:0] total_frames,
  output logic             framing_err,
  output logic             excess
);

  localparam logic [BITS-1:0] LAST_MASK = {BITS{1'b1}} >> (BITS - LAST_BITS);

  chan_state_t     state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [ERRW-1:0] acc_q, acc_d;
  logic [ERRW-1:0] pc_full, pc_last, errs_d;
  logic            done_d, fr_err_d;

  assign pc_full = ERRW'(popcount(32'(err)));
  assign pc_last = ERRW'(popcount(32'(err & LAST_MASK)));

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    errs_d   = acc_q + pc_last;
    fr_err_d = 1'b0;
    case (state_q)
      CH_IDLE: begin
        if (first) begin
          if (BEATS == 1) begin
            done_d = 1'b1;
            errs_d = pc_last;
          end else begin
            state_d = CH_ACTIVE;
            beat_d  = BW'(1);
            acc_d   = pc_full;
          end
        end
      end
      CH_ACTIVE: begin
        if (first) begin
          // Partial frame is dropped; this beat becomes beat 0 of a new one.
          fr_err_d = 1'b1;
          beat_d   = BW'(1);
          acc_d    = pc_full;
        end else if (beat_q == BW'(BEATS - 1)) begin
          done_d  = 1'b1;
          state_d = CH_IDLE;
          beat_d  = '0;
          acc_d   = '0;
        end else begin
          beat_d = beat_q + BW'(1);
          acc_d  = acc_q + pc_full;
        end
      end
      default: state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CH_IDLE;
      beat_q       <= '0;
      acc_q        <= '0;
      frame_done   <= 1'b0;
      frame_errs   <= '0;
      total_errs   <= '0;
      total_frames <= '0;
      framing_err  <= 1'b0;
      excess       <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      acc_q      <= acc_d;
      frame_done <= done_d;
      if (done_d) frame_errs <= errs_d;
      // A clear landing on a completion drops that frame from the statistics.
      if (clear) begin
        total_errs   <= '0;
        total_frames <= '0;
        framing_err  <= 1'b0;
        excess       <= 1'b0;
      end else begin
        if (fr_err_d) framing_err <= 1'b1;
        if (done_d) begin
          total_errs   <= CNT_W'(sat_add(32'(total_errs), 32'(errs_d), CNT_W));
          total_frames <= CNT_W'(sat_add(32'(total_frames), 32'd1, CNT_W));
          if (int'(errs_d) > T) excess <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bch_mchannel_err_stats.sv
// Multi-channel error statistics after bch_decoder: optional input delay line
// feeding one independent statistics channel per decoder lane.
module bch_mchannel_err_stats
  import bch_mchannel_err_stats_pkg::*;
#(
  parameter int T           = 3,
  parameter int DATA_BITS   = 64,
  parameter int BITS        = 4,
  parameter int NCHANNEL    = 4,
  parameter int PIPE_STAGES = 1,
  parameter int CNT_W       = 16,
  localparam int ERRW       = errw_f(DATA_BITS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NCHANNEL*BITS-1:0]  err_in,
  input  logic [NCHANNEL-1:0]       first_in,
  input  logic                      clear_in,
  output logic [NCHANNEL-1:0]       frame_done_out,
  output logic [NCHANNEL*ERRW-1:0]  frame_errs_out,
  output logic [NCHANNEL*CNT_W-1:0] total_errs_out,
  output logic [NCHANNEL*CNT_W-1:0] total_frames_out,
  output logic [NCHANNEL-1:0]       framing_err_out,
  output logic [NCHANNEL-1:0]       excess_out
);

  logic [NCHANNEL*BITS-1:0] err_dly;
  logic [NCHANNEL-1:0]      first_dly;

  generate
    if (PIPE_STAGES == 0) begin : g_direct
      assign err_dly   = err_in;
      assign first_dly = first_in;
    end else begin : g_pipe
      logic [NCHANNEL*BITS-1:0] err_q   [PIPE_STAGES];
      logic [NCHANNEL-1:0]      first_q [PIPE_STAGES];
      for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        if (s == 0) begin : g_head
          always_ff @(posedge clk) begin
            if (reset) begin
              err_q[0]   <= '0;
              first_q[0] <= '0;
            end else begin
              err_q[0]   <= err_in;
              first_q[0] <= first_in;
            end
          end
        end else begin : g_tail
          always_ff @(posedge clk) begin
            if (reset) begin
              err_q[s]   <= '0;
              first_q[s] <= '0;
            end else begin
              err_q[s]   <= err_q[s-1];
              first_q[s] <= first_q[s-1];
            end
          end
        end
      end
      assign err_dly   = err_q[PIPE_STAGES-1];
      assign first_dly = first_q[PIPE_STAGES-1];
    end
  endgenerate

  for (genvar c = 0; c < NCHANNEL; c++) begin : g_chan
    bch_err_chan_stats #(
      .T         (T),
      .DATA_BITS (DATA_BITS),
      .BITS      (BITS),
      .CNT_W     (CNT_W)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .err          (err_dly[c*BITS +: BITS]),
      .first        (first_dly[c]),
      .clear        (clear_in),
      .frame_done   (frame_done_out[c]),
      .frame_errs   (frame_errs_out[c*ERRW +: ERRW]),
      .total_errs   (total_errs_out[c*CNT_W +: CNT_W]),
      .total_frames (total_frames_out[c*CNT_W +: CNT_W]),
      .framing_err  (framing_err_out[c]),
      .excess       (excess_out[c])
    );
  end

endmodule

// File: tb/tb_bch_mchannel_err_stats.sv
// Randomized scoreboard bench: three configurations (default/PIPE=1, 62-bit
// frames with 4-bit counters and PIPE=0, PIPE=3) share one stimulus stream.
module tb_bch_mchannel_err_stats;

  localparam int NCH  = 4;
  localparam int BITS = 4;
  localparam int T    = 3;
  localparam int NCFG = 3;
  localparam int NRUN = 3500;

  typedef struct {
    int cyc;
    int errs;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NCH*BITS-1:0] err_in = '0;
  logic [NCH-1:0] first_in = '0;
  logic clear_in = 1'b0;

  logic [NCH-1:0] done_a, done_b, done_c;
  logic [NCH*7-1:0] errs_a, errs_c;
  logic [NCH*6-1:0] errs_b;
  logic [NCH*16-1:0] te_a, tf_a, te_c, tf_c;
  logic [NCH*4-1:0] te_b, tf_b;
  logic [NCH-1:0] fr_a, fr_b, fr_c, ex_a, ex_b, ex_c;

  always #5 clk = ~clk;

  bch_mchannel_err_stats #(.T(T), .DATA_BITS(64), .BITS(BITS), .NCHANNEL(NCH),
                           .PIPE_STAGES(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .err_in(err_in), .first_in(first_in), .clear_in(clear_in),
    .frame_done_out(done_a), .frame_errs_out(errs_a), .total_errs_out(te_a),
    .total_frames_out(tf_a), .framing_err_out(fr_a), .excess_out(ex_a));

  bch_mchannel_err_stats #(.T(T), .DATA_BITS(62), .BITS(BITS), .NCHANNEL(NCH),
                           .PIPE_STAGES(0), .CNT_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .err_in(err_in), .first_in(first_in), .clear_in(clear_in),
    .frame_done_out(done_b), .frame_errs_out(errs_b), .total_errs_out(te_b),
    .total_frames_out(tf_b), .framing_err_out(fr_b), .excess_out(ex_b));

  bch_mchannel_err_stats #(.T(T), .DATA_BITS(64), .BITS(BITS), .NCHANNEL(NCH),
                           .PIPE_STAGES(3), .CNT_W(16)) u_dut_c (
    .clk(clk), .reset(reset), .err_in(err_in), .first_in(first_in), .clear_in(clear_in),
    .frame_done_out(done_c), .frame_errs_out(errs_c), .total_errs_out(te_c),
    .total_frames_out(tf_c), .framing_err_out(fr_c), .excess_out(ex_c));

  function automatic int cfg_db(input int k);
    return (k == 1) ? 62 : 64;
  endfunction
  function automatic int cfg_pipe(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction
  function automatic int cfg_cntw(input int k);
    return (k == 1) ? 4 : 16;
  endfunction
  function automatic int cfg_beats(input int k);
    return (cfg_db(k) + BITS - 1) / BITS;
  endfunction
  function automatic logic [BITS-1:0] cfg_last_mask(input int k);
    int lb;
    lb = cfg_db(k) - (cfg_beats(k) - 1) * BITS;
    return BITS'((1 << lb) - 1);
  endfunction

  function automatic int get_done(input int k, input int c);
    case (k)
      0: return int'(done_a[c]);
      1: return int'(done_b[c]);
      default: return int'(done_c[c]);
    endcase
  endfunction
  function automatic int get_errs(input int k, input int c);
    case (k)
      0: return int'(errs_a[c*7 +: 7]);
      1: return int'(errs_b[c*6 +: 6]);
      default: return int'(errs_c[c*7 +: 7]);
    endcase
  endfunction
  function automatic int get_te(input int k, input int c);
    case (k)
      0: return int'(te_a[c*16 +: 16]);
      1: return int'(te_b[c*4 +: 4]);
      default: return int'(te_c[c*16 +: 16]);
    endcase
  endfunction
  function automatic int get_tf(input int k, input int c);
    case (k)
      0: return int'(tf_a[c*16 +: 16]);
      1: return int'(tf_b[c*4 +: 4]);
      default: return int'(tf_c[c*16 +: 16]);
    endcase
  endfunction
  function automatic int get_fr(input int k, input int c);
    case (k)
      0: return int'(fr_a[c]);
      1: return int'(fr_b[c]);
      default: return int'(fr_c[c]);
    endcase
  endfunction
  function automatic int get_ex(input int k, input int c);
    case (k)
      0: return int'(ex_a[c]);
      1: return int'(ex_b[c]);
      default: return int'(ex_c[c]);
    endcase
  endfunction

  // Input history, indexed by cycle.
  logic [NCH*BITS-1:0] h_err [NRUN];
  logic [NCH-1:0]      h_first [NRUN];
  bit                  h_rst [NRUN];
  bit                  h_clr [NRUN];

  // Reference model: beats collected since the last first, plus statistics.
  logic [BITS-1:0] m_beat [NCFG][NCH][16];
  int m_nb [NCFG][NCH];
  int m_last [NCFG][NCH];
  int m_te [NCFG][NCH];
  int m_tf [NCFG][NCH];
  int m_fr [NCFG][NCH];
  int m_ex [NCFG][NCH];
  exp_t sbq [NCFG][NCH][$];

  int tests = 0;
  int failures = 0;
  int cyc = -1;
  bit stop_mon = 1'b0;

  function automatic int sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic chk(input string name, input int k, input int c, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cfg%0d ch%0d cycle %0d: got %0d, expected %0d", name, k, c, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int k, input int m);
    int p;
    bit flushed;
    logic [NCH*BITS-1:0] e;
    logic [NCH-1:0] f;
    logic [BITS-1:0] b;
    bit done;
    bit fr_set;
    int errs;
    int nb;
    p = cfg_pipe(k);
    flushed = 1'b0;
    e = '0;
    f = '0;
    if (p == 0) begin
      e = h_err[m];
      f = h_first[m];
    end else if (m >= p) begin
      for (int j = m - p; j < m; j++) if (h_rst[j]) flushed = 1'b1;
      if (!flushed) begin
        e = h_err[m-p];
        f = h_first[m-p];
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (h_rst[m]) begin
        m_nb[k][c] = 0; m_last[k][c] = 0; m_te[k][c] = 0;
        m_tf[k][c] = 0; m_fr[k][c] = 0; m_ex[k][c] = 0;
      end else begin
        done = 1'b0;
        fr_set = 1'b0;
        errs = 0;
        b = e[c*BITS +: BITS];
        if (f[c]) begin
          if (m_nb[k][c] != 0) fr_set = 1'b1;
          m_beat[k][c][0] = b;
          m_nb[k][c] = 1;
        end else if (m_nb[k][c] != 0) begin
          nb = m_nb[k][c];
          m_beat[k][c][nb] = b;
          m_nb[k][c] = nb + 1;
        end
        if (m_nb[k][c] == cfg_beats(k)) begin
          done = 1'b1;
          for (int i = 0; i < cfg_beats(k); i++)
            errs += (i == cfg_beats(k) - 1) ? $countones(m_beat[k][c][i] & cfg_last_mask(k))
                                            : $countones(m_beat[k][c][i]);
          m_nb[k][c] = 0;
        end
        if (h_clr[m]) begin
          m_te[k][c] = 0; m_tf[k][c] = 0; m_fr[k][c] = 0; m_ex[k][c] = 0;
        end else begin
          if (fr_set) m_fr[k][c] = 1;
          if (done) begin
            m_te[k][c] = sat(m_te[k][c] + errs, cfg_cntw(k));
            m_tf[k][c] = sat(m_tf[k][c] + 1, cfg_cntw(k));
            if (errs > T) m_ex[k][c] = 1;
          end
        end
        if (done) begin
          m_last[k][c] = errs;
          sbq[k][c].push_back('{cyc: m, errs: errs});
        end
      end
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    int exp_done;
    exp_t ent;
    forever begin
      @(posedge clk);
      #1;
      if (cyc >= 0 && !stop_mon) begin
        for (int k = 0; k < NCFG; k++) begin
          for (int c = 0; c < NCH; c++) begin
            exp_done = (sbq[k][c].size() > 0 && sbq[k][c][0].cyc == cyc) ? 1 : 0;
            chk("frame_done", k, c, get_done(k, c), exp_done);
            if (exp_done == 1) begin
              ent = sbq[k][c].pop_front();
              chk("frame_errs_at_done", k, c, get_errs(k, c), ent.errs);
            end
            chk("frame_errs_held", k, c, get_errs(k, c), m_last[k][c]);
            chk("total_errs", k, c, get_te(k, c), m_te[k][c]);
            chk("total_frames", k, c, get_tf(k, c), m_tf[k][c]);
            chk("framing_err", k, c, get_fr(k, c), m_fr[k][c]);
            chk("excess", k, c, get_ex(k, c), m_ex[k][c]);
          end
        end
      end
    end
  end

  // Driver: per-channel frame generator with occasional mid-frame restarts.
  initial begin
    int gen_pos [NCH];
    bit rst_v, rst_prev, clr_v, quiet;
    logic [NCH*BITS-1:0] ev;
    logic [NCH-1:0] fv;
    logic [BITS-1:0] bv;
    for (int c = 0; c < NCH; c++) gen_pos[c] = 0;
    for (int k = 0; k < NCFG; k++)
      for (int c = 0; c < NCH; c++) begin
        m_nb[k][c] = 0; m_last[k][c] = 0; m_te[k][c] = 0;
        m_tf[k][c] = 0; m_fr[k][c] = 0; m_ex[k][c] = 0;
      end
    rst_prev = 1'b1;
    for (int i = 0; i < NRUN; i++) begin
      @(negedge clk);
      cyc = i;
      quiet = (i >= NRUN - 40);
      rst_v = (i < 5) || (i >= 1000 && i < 1002) || (i == 2500) || (i == 2777);
      clr_v = (i >= 1800 && i < 3000 && $urandom_range(99) < 2) || (i == 3100);
      ev = '0;
      fv = '0;
      for (int c = 0; c < NCH; c++) begin
        bv = ($urandom_range(1) == 0) ? BITS'($urandom & $urandom & $urandom) : BITS'($urandom & $urandom);
        if (quiet) bv = '0;
        if (rst_v) begin
          gen_pos[c] = 0;
        end else if (quiet) begin
          gen_pos[c] = 0;
        end else if (gen_pos[c] == 0) begin
          if (rst_prev || $urandom_range(9) < 7) begin
            fv[c] = 1'b1;
            gen_pos[c] = 1;
          end
        end else if ($urandom_range(99) < 3) begin
          fv[c] = 1'b1;
          gen_pos[c] = 1;
        end else begin
          gen_pos[c] = (gen_pos[c] + 1) % 16;
        end
        ev[c*BITS +: BITS] = bv;
      end
      reset = rst_v;
      clear_in = clr_v;
      err_in = ev;
      first_in = fv;
      h_err[i] = ev;
      h_first[i] = fv;
      h_rst[i] = rst_v;
      h_clr[i] = clr_v;
      for (int k = 0; k < NCFG; k++) model_step(k, i);
      rst_prev = rst_v;
    end
    @(negedge clk);
    stop_mon = 1'b1;
    for (int k = 0; k < NCFG; k++)
      for (int c = 0; c < NCH; c++)
        chk("pending_done_left", k, c, sbq[k][c].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
